// File: rtl/reset_init_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : reset_init_sequencer_if
// Description : Control/status bundle for reset_init_sequencer.
//               Signal suffixes are named from the sequencer's point of view.
//   rearm_req_i    1       single-cycle pulse, restarts the release sequence
//   hold_i         1       freezes the sequence counter while high
//   ch_release_o   NUM_CH  1 = channel i released
//   all_released_o 1       every channel released
//   seq_count_o    CNT_W   current sequence counter value
//   timeout_o      1       sticky watchdog flag
// Revision    : 1.0 - initial release
// ============================================================================
interface reset_init_sequencer_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 16
);
  logic              rearm_req_i;
  logic              hold_i;
  logic [NUM_CH-1:0] ch_release_o;
  logic              all_released_o;
  logic [CNT_W-1:0]  seq_count_o;
  logic              timeout_o;

  // The sequencer itself.
  modport slave (
    input  rearm_req_i, hold_i,
    output ch_release_o, all_released_o, seq_count_o, timeout_o
  );

  // Whoever drives the sequencer controls and watches its status.
  modport master (
    output rearm_req_i, hold_i,
    input  ch_release_o, all_released_o, seq_count_o, timeout_o
  );
endinterface
`default_nettype wire

// File: rtl/reset_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_init_sequencer
// Description : Staged reset/init release sequencer. After reset, NUM_CH
//               release outputs are set one by one, each CH_DELAY[i] unheld
//               counting cycles after sequencing starts. Supports hold,
//               soft re-arm (replay) and a run-length watchdog.
//   clock_i  in   sole clock
//   reset_i  in   asynchronous, active-high reset
//   bus      if   reset_init_sequencer_if.slave (controls and status)
// Revision    : 1.0 - initial release
// ============================================================================
module reset_init_sequencer #(
  parameter int unsigned                   NUM_CH         = 2,
  parameter int unsigned                   CNT_W          = 16,
  parameter logic [NUM_CH*CNT_W-1:0]       CH_DELAY       = {16'd50, 16'd30},
  parameter int unsigned                   TIMEOUT_CYCLES = 0,
  parameter int unsigned                   TO_W           = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  reset_init_sequencer_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_REARM = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_num_ch
    $fatal(1, "reset_init_sequencer: NUM_CH must be in 1..16");
  end

  logic [1:0]        state_q, state_d, state_pre;
  logic [CNT_W-1:0]  seq_count_q, seq_count_d;
  logic [NUM_CH-1:0] ch_release_q, ch_release_d;
  logic [NUM_CH-1:0] ch_hit;
  logic              all_released_q, all_released_d;
  logic              upd;    // release compare applies on this edge
  logic              rearm;  // clear everything on this edge

  // ch_hit[i]: the counter value being entered equals channel i's delay.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_hit[i] = (seq_count_d == CH_DELAY[i*CNT_W +: CNT_W]);
    if ((64'(CH_DELAY[i*CNT_W +: CNT_W]) >> CNT_W) != 64'd0) begin : g_bad_delay
      $fatal(1, "reset_init_sequencer: CH_DELAY slice does not fit in CNT_W");
    end
  end

  // Counter / state progression. Priority: rearm > hold > increment.
  always_comb begin
    state_pre   = state_q;
    seq_count_d = seq_count_q;
    upd         = 1'b0;
    rearm       = 1'b0;
    case (state_q)
      // COUNT entry edge: counter stays 0, zero-delay channels release here.
      ST_IDLE, ST_REARM: begin
        state_pre = ST_COUNT;
        upd       = 1'b1;
      end
      ST_COUNT: begin
        if (bus.rearm_req_i) begin
          rearm       = 1'b1;
          state_pre   = ST_REARM;
          seq_count_d = '0;
        end else if (all_released_q) begin
          // Only reachable when every delay is zero.
          state_pre = ST_DONE;
        end else if (!bus.hold_i) begin
          if (seq_count_q != CNT_MAX) begin
            seq_count_d = seq_count_q + 1'b1;
          end
          upd = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.rearm_req_i) begin
          rearm       = 1'b1;
          state_pre   = ST_REARM;
          seq_count_d = '0;
        end
      end
      default: state_pre = ST_IDLE;
    endcase
  end

  // Release bits are sticky; the last one completes the sequence.
  always_comb begin
    ch_release_d = ch_release_q;
    state_d      = state_pre;
    if (rearm) begin
      ch_release_d = '0;
    end else if (upd) begin
      ch_release_d = ch_release_q | ch_hit;
    end
    all_released_d = &ch_release_d;
    if ((state_q == ST_COUNT) && upd && all_released_d) begin
      state_d = ST_DONE;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      seq_count_q    <= '0;
      ch_release_q   <= '0;
      all_released_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      seq_count_q    <= seq_count_d;
      ch_release_q   <= ch_release_d;
      all_released_q <= all_released_d;
    end
  end

  assign bus.ch_release_o   = ch_release_q;
  assign bus.all_released_o = all_released_q;
  assign bus.seq_count_o    = seq_count_q;

  if (TIMEOUT_CYCLES > 0) begin : g_wd
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    // Counts run length in COUNT and DONE regardless of hold.
    always_comb begin
      wd_d      = wd_q;
      timeout_d = timeout_q;
      if (rearm) begin
        wd_d      = '0;
        timeout_d = 1'b0;
      end else if ((state_q == ST_COUNT) || (state_q == ST_DONE)) begin
        if (wd_q != {TO_W{1'b1}}) begin
          wd_d = wd_q + 1'b1;
        end
        if (wd_d == TO_LIMIT) begin
          timeout_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
        wd_q      <= '0;
        timeout_q <= 1'b0;
      end else begin
        wd_q      <= wd_d;
        timeout_q <= timeout_d;
      end
    end

    assign bus.timeout_o = timeout_q;
  end else begin : g_no_wd
    assign bus.timeout_o = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_reset_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_init_sequencer
// Description : Directed bench for reset_init_sequencer. Three instances:
//               A default (hold, rearm, mid-run reset), B with a 100-cycle
//               watchdog (plain run + timeout), C with delays {5,0}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_init_sequencer;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic rst_c = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = -1;  // edges since COUNT entry (entry edge = 0)

  always #5 clk = ~clk;

  reset_init_sequencer_if #(.NUM_CH(2), .CNT_W(16)) if_a ();
  reset_init_sequencer_if #(.NUM_CH(2), .CNT_W(16)) if_b ();
  reset_init_sequencer_if #(.NUM_CH(2), .CNT_W(16)) if_c ();

  reset_init_sequencer u_a (
    .clock_i (clk),
    .reset_i (rst_a),
    .bus     (if_a)
  );

  reset_init_sequencer #(.TIMEOUT_CYCLES(100)) u_b (
    .clock_i (clk),
    .reset_i (rst_b),
    .bus     (if_b)
  );

  reset_init_sequencer #(.CH_DELAY({16'd5, 16'd0})) u_c (
    .clock_i (clk),
    .reset_i (rst_c),
    .bus     (if_c)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    if_a.rearm_req_i = 1'b0; if_a.hold_i = 1'b0;
    if_b.rearm_req_i = 1'b0; if_b.hold_i = 1'b0;
    if_c.rearm_req_i = 1'b0; if_c.hold_i = 1'b0;

    // Reset state, before any clock edge
    #1;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    #1;
    chk("rst_ch",   64'(if_a.ch_release_o),   64'd0);
    chk("rst_all",  64'(if_a.all_released_o), 64'd0);
    chk("rst_seq",  64'(if_a.seq_count_o),    64'd0);
    chk("rst_to_b", 64'(if_b.timeout_o),      64'd0);
    chk("rst_ch_c", 64'(if_c.ch_release_o),   64'd0);

    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    goto(0);
    chk("a_entry_seq", 64'(if_a.seq_count_o),    64'd0);
    chk("a_entry_ch",  64'(if_a.ch_release_o),   64'd0);
    chk("c_entry_ch",  64'(if_c.ch_release_o),   64'd1);
    chk("c_entry_all", 64'(if_c.all_released_o), 64'd0);

    goto(4);
    chk("c_ch_c4", 64'(if_c.ch_release_o), 64'd1);
    goto(5);
    chk("c_ch_c5",  64'(if_c.ch_release_o),   64'd3);
    chk("c_all_c5", 64'(if_c.all_released_o), 64'd1);
    chk("c_seq_c5", 64'(if_c.seq_count_o),    64'd5);

    // Hold A for five edges starting at seq_count=10
    goto(10);
    chk("a_seq_c10", 64'(if_a.seq_count_o), 64'd10);
    if_a.hold_i = 1'b1;
    goto(13);
    chk("a_hold_c13", 64'(if_a.seq_count_o), 64'd10);
    goto(15);
    chk("a_hold_c15", 64'(if_a.seq_count_o), 64'd10);
    if_a.hold_i = 1'b0;
    goto(16);
    chk("a_seq_c16", 64'(if_a.seq_count_o), 64'd11);

    goto(29);
    chk("b_ch_c29", 64'(if_b.ch_release_o), 64'd0);
    goto(30);
    chk("b_ch_c30",  64'(if_b.ch_release_o), 64'd1);
    chk("b_seq_c30", 64'(if_b.seq_count_o),  64'd30);

    goto(34);
    chk("a_ch_c34", 64'(if_a.ch_release_o), 64'd0);
    goto(35);
    chk("a_ch_c35",  64'(if_a.ch_release_o), 64'd1);
    chk("a_seq_c35", 64'(if_a.seq_count_o),  64'd30);

    // Rearm A at seq_count=40 with hold also high
    goto(45);
    chk("a_seq_c45", 64'(if_a.seq_count_o), 64'd40);
    if_a.rearm_req_i = 1'b1;
    if_a.hold_i      = 1'b1;
    goto(46);
    chk("a_rearm_ch",  64'(if_a.ch_release_o),   64'd0);
    chk("a_rearm_seq", 64'(if_a.seq_count_o),    64'd0);
    chk("a_rearm_all", 64'(if_a.all_released_o), 64'd0);
    if_a.rearm_req_i = 1'b0;
    if_a.hold_i      = 1'b0;
    goto(47);
    chk("a_reentry_seq", 64'(if_a.seq_count_o), 64'd0);

    goto(49);
    chk("b_ch_c49",  64'(if_b.ch_release_o),   64'd1);
    chk("b_all_c49", 64'(if_b.all_released_o), 64'd0);
    goto(50);
    chk("b_ch_c50",  64'(if_b.ch_release_o),   64'd3);
    chk("b_all_c50", 64'(if_b.all_released_o), 64'd1);
    chk("b_seq_c50", 64'(if_b.seq_count_o),    64'd50);

    goto(60);
    chk("b_seq_frozen", 64'(if_b.seq_count_o), 64'd50);
    chk("c_seq_frozen", 64'(if_c.seq_count_o), 64'd5);

    goto(76);
    chk("a_ch_c76",  64'(if_a.ch_release_o), 64'd0);
    chk("a_seq_c76", 64'(if_a.seq_count_o),  64'd29);
    goto(77);
    chk("a_ch_c77",  64'(if_a.ch_release_o), 64'd1);
    chk("a_seq_c77", 64'(if_a.seq_count_o),  64'd30);

    // Asynchronous reset of A between clock edges
    goto(80);
    #3;
    rst_a = 1'b1;
    #1;
    chk("a_async_ch",  64'(if_a.ch_release_o),   64'd0);
    chk("a_async_seq", 64'(if_a.seq_count_o),    64'd0);
    chk("a_async_all", 64'(if_a.all_released_o), 64'd0);
    #2;
    rst_a = 1'b0;
    goto(81);
    chk("a_restart_seq", 64'(if_a.seq_count_o),  64'd0);
    chk("a_restart_ch",  64'(if_a.ch_release_o), 64'd0);

    // Watchdog on B
    goto(99);
    chk("b_to_c99", 64'(if_b.timeout_o), 64'd0);
    goto(100);
    chk("b_to_c100", 64'(if_b.timeout_o), 64'd1);
    chk("a_to_off",  64'(if_a.timeout_o), 64'd0);
    goto(110);
    chk("b_to_c110", 64'(if_b.timeout_o), 64'd1);
    if_b.rearm_req_i = 1'b1;
    goto(111);
    chk("b_to_clr",    64'(if_b.timeout_o),    64'd0);
    chk("b_rearm_ch",  64'(if_b.ch_release_o), 64'd0);
    chk("b_rearm_seq", 64'(if_b.seq_count_o),  64'd0);
    chk("a_ch_c111",   64'(if_a.ch_release_o), 64'd1);
    chk("a_seq_c111",  64'(if_a.seq_count_o),  64'd30);
    if_b.rearm_req_i = 1'b0;
    goto(113);
    chk("b_seq_c113", 64'(if_b.seq_count_o), 64'd1);
    chk("b_to_c113",  64'(if_b.timeout_o),   64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
